// File: rtl/morse_pkg.sv
// Shared types, symbol codes and the Morse code table for the stream decoder.
package morse_pkg;

   typedef logic [5:0] morse_code_t;

   localparam morse_code_t CODE_SPACE   = 6'd36;
   localparam morse_code_t CODE_INVALID = 6'd63;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MARK = 2'd1,
      ST_GAP  = 2'd2
   } morse_state_t;

   // The pattern stores the first element at bit 0; the table is keyed on the
   // reading-order sequence (first element in the MSB of the used bits).
   function automatic morse_code_t morse_lookup(input logic [2:0] len, input logic [4:0] pattern);
      logic [4:0]  seq;
      morse_code_t code;
      seq = 5'd0;
      for (int i = 0; i < 5; i++) begin
         if (3'(i) < len) begin
            seq = {seq[3:0], pattern[i]};
         end else begin
            seq = seq;
         end
      end
      case ({len, seq})
         {3'd2, 5'b00001}: code = 6'd0;
         {3'd4, 5'b01000}: code = 6'd1;
         {3'd4, 5'b01010}: code = 6'd2;
         {3'd3, 5'b00100}: code = 6'd3;
         {3'd1, 5'b00000}: code = 6'd4;
         {3'd4, 5'b00010}: code = 6'd5;
         {3'd3, 5'b00110}: code = 6'd6;
         {3'd4, 5'b00000}: code = 6'd7;
         {3'd2, 5'b00000}: code = 6'd8;
         {3'd4, 5'b00111}: code = 6'd9;
         {3'd3, 5'b00101}: code = 6'd10;
         {3'd4, 5'b00100}: code = 6'd11;
         {3'd2, 5'b00011}: code = 6'd12;
         {3'd2, 5'b00010}: code = 6'd13;
         {3'd3, 5'b00111}: code = 6'd14;
         {3'd4, 5'b00110}: code = 6'd15;
         {3'd4, 5'b01101}: code = 6'd16;
         {3'd3, 5'b00010}: code = 6'd17;
         {3'd3, 5'b00000}: code = 6'd18;
         {3'd1, 5'b00001}: code = 6'd19;
         {3'd3, 5'b00001}: code = 6'd20;
         {3'd4, 5'b00001}: code = 6'd21;
         {3'd3, 5'b00011}: code = 6'd22;
         {3'd4, 5'b01001}: code = 6'd23;
         {3'd4, 5'b01011}: code = 6'd24;
         {3'd4, 5'b01100}: code = 6'd25;
         {3'd5, 5'b11111}: code = 6'd26;
         {3'd5, 5'b01111}: code = 6'd27;
         {3'd5, 5'b00111}: code = 6'd28;
         {3'd5, 5'b00011}: code = 6'd29;
         {3'd5, 5'b00001}: code = 6'd30;
         {3'd5, 5'b00000}: code = 6'd31;
         {3'd5, 5'b10000}: code = 6'd32;
         {3'd5, 5'b11000}: code = 6'd33;
         {3'd5, 5'b11100}: code = 6'd34;
         {3'd5, 5'b11110}: code = 6'd35;
         default:          code = CODE_INVALID;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/morse_out_buf.sv
// One-deep valid/ready output register with a sticky overflow flag for
// symbols that arrive while the held one is still undelivered.
module morse_out_buf #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic [W-1:0] dout,
   output logic         valid,
   output logic         overflow
);

   // Hold, replace or drop the buffered symbol and track overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout     <= '0;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else if (load && (!valid || ready)) begin
         dout  <= din;
         valid <= 1'b1;
      end else if (load) begin
         overflow <= 1'b1;
      end else if (ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/morse_stream_decoder.sv
// Decodes an on/off keyed Morse stream into A-Z, 0-9 and word-space codes,
// delivered through a one-deep valid/ready buffer.
module morse_stream_decoder
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4,
   parameter int MAX_ELEM    = 5,
   parameter int CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in,
   output logic [5:0] out_code,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       overflow,
   output logic       busy
);

   localparam logic [CNT_W-1:0] RUN_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DOT_LIM  = CNT_W'(2 * UNIT_CYCLES);
   localparam logic [CNT_W-1:0] WORD_LIM = CNT_W'(5 * UNIT_CYCLES);

   logic             sync1_r;
   logic             s_in_r;
   logic [CNT_W-1:0] run_r;
   morse_state_t     state_r;
   logic [4:0]       pat_r;
   logic [2:0]       len_r;
   logic             inv_r;
   logic             word_pending_r;
   logic             busy_r;
   logic             rise_s;
   logic             fall_s;
   logic             emit_s;
   morse_code_t      emit_code_s;

   // sync1_r holds the next s_in value, so edges are seen on the cycle they land
   // and run_r always equals the length of the current s_in run so far.
   assign rise_s = sync1_r & ~s_in_r;
   assign fall_s = ~sync1_r & s_in_r;

   // Input synchroniser and saturating run-length counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         s_in_r  <= 1'b0;
         run_r   <= '0;
      end else begin
         sync1_r <= in;
         s_in_r  <= sync1_r;
         if (sync1_r != s_in_r) begin
            run_r <= RUN_ONE;
         end else if (run_r != RUN_MAX) begin
            run_r <= run_r + RUN_ONE;
         end else begin
            run_r <= run_r;
         end
      end
   end

   // Symbol emission: letter at the gap threshold, word space at the word threshold.
   always_comb begin
      emit_s      = 1'b0;
      emit_code_s = CODE_SPACE;
      case (state_r)
         ST_GAP: begin
            if (run_r == DOT_LIM) begin
               emit_s      = 1'b1;
               emit_code_s = inv_r ? CODE_INVALID : morse_lookup(len_r, pat_r);
            end else begin
               emit_s = 1'b0;
            end
         end
         ST_IDLE: begin
            if (word_pending_r && !s_in_r && run_r == WORD_LIM) begin
               emit_s      = 1'b1;
               emit_code_s = CODE_SPACE;
            end else begin
               emit_s = 1'b0;
            end
         end
         default: begin
            emit_s      = 1'b0;
            emit_code_s = CODE_SPACE;
         end
      endcase
   end

   // Symbol FSM and element buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         pat_r          <= 5'd0;
         len_r          <= 3'd0;
         inv_r          <= 1'b0;
         word_pending_r <= 1'b0;
         busy_r         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (emit_s) begin
                  word_pending_r <= 1'b0;
               end
               if (rise_s) begin
                  state_r <= ST_MARK;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end
            end
            ST_MARK: begin
               if (fall_s) begin
                  // A sixth element poisons the symbol; the length stays at the limit.
                  if (len_r == 3'(MAX_ELEM)) begin
                     inv_r <= 1'b1;
                  end else begin
                     pat_r <= pat_r | (5'(run_r >= DOT_LIM) << len_r);
                     len_r <= len_r + 3'd1;
                  end
                  state_r <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (emit_s) begin
                  pat_r          <= 5'd0;
                  len_r          <= 3'd0;
                  inv_r          <= 1'b0;
                  word_pending_r <= 1'b1;
                  if (rise_s) begin
                     state_r <= ST_MARK;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else if (rise_s) begin
                  state_r <= ST_MARK;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;

   morse_out_buf #(.W(6)) u_out_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (emit_s),
      .din      (emit_code_s),
      .ready    (out_ready),
      .dout     (out_code),
      .valid    (out_valid),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_morse_stream_decoder.sv
// Self-checking bench for morse_stream_decoder: directed scenarios plus random
// symbol streams scored against a run-length level reference model.
module tb_morse_stream_decoder;

   localparam int U = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in = 1'b0;
   logic       out_ready = 1'b1;
   logic [5:0] out_code;
   logic       out_valid;
   logic       overflow;
   logic       busy;

   int    n_checks = 0;
   int    n_fail = 0;
   int    exp_q[$];
   int    got_q[$];
   string m_elems = "";
   bit    m_pending = 1'b0;

   string tbl [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                       "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                       "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-",
                       ".....", "-....", "--...", "---..", "----."};

   morse_stream_decoder #(.UNIT_CYCLES(U), .MAX_ELEM(5), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in        (in),
      .out_code  (out_code),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Record every delivered symbol, sampled half a cycle before the transfer edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(int'(out_code));
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int ref_code(string s);
      if (s.len() > 5) return 63;
      for (int i = 0; i < 36; i++) if (tbl[i] == s) return i;
      return 63;
   endfunction

   // Reference model: consumes whole runs of the keyed line.
   task automatic model_run(bit level, int dur);
      if (level) begin
         m_elems = {m_elems, (dur < 2 * U) ? "." : "-"};
      end else begin
         if (m_elems.len() > 0 && dur >= 2 * U) begin
            exp_q.push_back(ref_code(m_elems));
            m_elems = "";
            m_pending = 1'b1;
         end
         if (m_elems.len() == 0 && m_pending && dur >= 5 * U) begin
            exp_q.push_back(36);
            m_pending = 1'b0;
         end
      end
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic drive_run(bit level, int dur);
      model_run(level, dur);
      in = level;
      repeat (dur) @(posedge clk);
      #1;
   endtask

   task automatic send_sym(string s, int dot_len, int dash_len, int gap_len);
      for (int i = 0; i < s.len(); i++) begin
         drive_run(1'b1, (s[i] == 8'h2E) ? dot_len : dash_len);
         if (i < s.len() - 1) drive_run(1'b0, gap_len);
      end
   endtask

   task automatic check_stream(string name);
      int n;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (got_q.size() !== exp_q.size()) begin
         n_fail++;
         $display("FAIL %s count: got %0d symbols, expected %0d", name, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         n_checks++;
         if (got_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s symbol %0d: got %0d, expected %0d", name, i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_outputs(string name, logic [5:0] code, logic v, logic ov, logic b);
      n_checks++;
      if (out_code !== code || out_valid !== v || overflow !== ov || busy !== b) begin
         n_fail++;
         $display("FAIL %s: got code=%0d valid=%b ovf=%b busy=%b, expected code=%0d valid=%b ovf=%b busy=%b",
                  name, out_code, out_valid, overflow, busy, code, v, ov, b);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      check_outputs("reset_async", 6'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_outputs("reset_idle", 6'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_e();
      send_sym(".", 4, 12, 4);
      drive_run(1'b0, 10);
      check_stream("letter_e");
      check_outputs("e_no_overflow", 6'd4, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_sos();
      send_sym("...", 4, 12, 4);
      drive_run(1'b0, 12);
      send_sym("---", 4, 12, 4);
      drive_run(1'b0, 12);
      send_sym("...", 4, 12, 4);
      drive_run(1'b0, 10);
      check_stream("sos");
   endtask

   task automatic test_word();
      send_sym(".-", 4, 12, 4);
      drive_run(1'b0, 28);
      send_sym("-", 4, 12, 4);
      drive_run(1'b0, 10);
      check_stream("word_space");
   endtask

   task automatic test_boundary();
      send_sym("-.-", 7, 8, 7);
      drive_run(1'b0, 8);
      send_sym(".", 7, 8, 7);
      drive_run(1'b0, 19);
      send_sym("-", 7, 8, 7);
      drive_run(1'b0, 20);
      check_stream("thresholds");
   endtask

   task automatic test_digits();
      send_sym(".....", 4, 12, 4);
      drive_run(1'b0, 10);
      send_sym("......", 4, 12, 4);
      drive_run(1'b0, 10);
      drive_run(1'b1, 300);
      drive_run(1'b0, 10);
      check_stream("digits_invalid_stuck");
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      send_sym(".", 4, 12, 4);
      drive_run(1'b0, 10);
      send_sym("-", 4, 12, 4);
      drive_run(1'b0, 24);
      // T and the following word space are dropped while E is held.
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
      repeat (4) @(posedge clk);
      #1;
      check_outputs("overflow_hold", 6'd4, 1'b1, 1'b1, 1'b0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("overflow_drained", 6'd4, 1'b0, 1'b1, 1'b0);
      check_stream("overflow_stream");
   endtask

   task automatic test_reset_mid();
      in = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_mid_dash: got %b, expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      check_outputs("reset_mid_dash", 6'd0, 1'b0, 1'b0, 1'b0);
      in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_elems = "";
      m_pending = 1'b0;
      got_q.delete();
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      send_sym(".", 4, 12, 4);
      drive_run(1'b0, 10);
      check_stream("after_reset_e");
   endtask

   task automatic test_random();
      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < 4; k++) begin
            string s;
            s = tbl[$urandom_range(35, 0)];
            for (int i = 0; i < s.len(); i++) begin
               drive_run(1'b1, (s[i] == 8'h2E) ? int'($urandom_range(7, 1)) : int'($urandom_range(20, 8)));
               if (i < s.len() - 1) drive_run(1'b0, int'($urandom_range(7, 1)));
            end
            drive_run(1'b0, (k == 3) ? 25 : int'($urandom_range(30, 8)));
         end
         check_stream("random_stream");
      end
   endtask

   initial begin
      test_reset();
      test_e();
      test_sos();
      test_word();
      test_boundary();
      test_digits();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
